// File: rtl/b16_bus_pkg.sv
// b16_bus_pkg: shared b16 bus constants and SRAM controller state encoding
package b16_bus_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int SRAM_WAIT_DEFAULT = 2;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: wait-state sequencer between the b16 bus and a 16-bit async SRAM
module sram_ctrl
  import b16_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
  parameter int ADDR_PAD    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  r,
  input  logic [1:0]            w,
  input  logic [15:0]           addr,
  input  logic [15:0]           din,
  input  logic                  run,
  output logic [15:0]           dout,
  output logic                  ready,
  output logic [ADDR_PAD+14:0]  sram_addr,
  input  logic [15:0]           sram_dq_in,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] lw;
  logic       wr;
  logic       req;
  logic       active;
  assign req = sel & (r | (|w));
  // access sequencer: latch the request in IDLE, time the strobe pulse, capture read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lw          <= '0;
      wr          <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      dout        <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          state       <= S_SETUP;
          wr          <= |w;
          lw          <= w;
          sram_addr   <= {{ADDR_PAD{1'b0}}, addr[15:1]};
          sram_dq_out <= din;
        end
        S_SETUP: begin
          state <= S_PULSE;
          cnt   <= 4'(WAIT_CYCLES - 1);
        end
        S_PULSE: if (cnt == 4'd0) begin
          state <= S_DONE;
          if (!wr) dout <= sram_dq_in;
        end else cnt <= cnt - 4'd1;
        default: if (run || !sel) state <= S_IDLE;
      endcase
    end
  end
  // strobe decode from state; write hold keeps dq driven through DONE
  always_comb begin
    active     = state != S_IDLE;
    sram_ce_n  = ~active;
    sram_oe_n  = ~(state == S_PULSE && !wr);
    sram_we_n  = ~(state == S_PULSE && wr);
    sram_dq_oe = active && wr;
    sram_ub_n  = ~active | (wr & ~lw[1]);
    sram_lb_n  = ~active | (wr & ~lw[0]);
    ready      = reset | ~req | (state == S_DONE);
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl at WAIT_CYCLES 2, 1 and 15
module tb_sram_ctrl;
  localparam int WC [3] = '{2, 1, 15};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0, r = 1'b0, run = 1'b0;
  logic [1:0] w = 2'b00;
  logic [15:0] addr = '0, din = '0;
  logic [2:0][15:0] dout_a, dq_out_a;
  logic [2:0][17:0] addr_a;
  logic [2:0] ready_a, oe_a, ce_a, oen_a, wen_a, ub_a, lb_a;
  logic [15:0] dq_model;
  logic [15:0] mem [0:255];
  logic ld = 1'b0;
  logic [7:0] ld_a = '0;
  logic [15:0] ld_d = '0;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_ctrl #(.WAIT_CYCLES(WC[g]), .ADDR_PAD(3)) u (
      .clk(clk), .reset(reset), .sel(sel), .r(r), .w(w), .addr(addr), .din(din), .run(run),
      .dout(dout_a[g]), .ready(ready_a[g]), .sram_addr(addr_a[g]), .sram_dq_in(dq_model),
      .sram_dq_out(dq_out_a[g]), .sram_dq_oe(oe_a[g]), .sram_ce_n(ce_a[g]), .sram_oe_n(oen_a[g]),
      .sram_we_n(wen_a[g]), .sram_ub_n(ub_a[g]), .sram_lb_n(lb_a[g])
    );
  end
  assign dq_model = (!ce_a[0] && !oen_a[0]) ? mem[addr_a[0][7:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (ld) mem[ld_a] <= ld_d;
    else if (!ce_a[0] && !wen_a[0] && oe_a[0]) begin
      if (!ub_a[0]) mem[addr_a[0][7:0]][15:8] <= dq_out_a[0][15:8];
      if (!lb_a[0]) mem[addr_a[0][7:0]][7:0] <= dq_out_a[0][7:0];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int nwe, noe;
    int lat [3];
    tick();
    ld = 1'b1; ld_a = 8'h34; ld_d = 16'hBEEF;
    tick();
    ld_a = 8'h08; ld_d = 16'h1234;
    tick();
    ld = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_a[0], 1);
    chk("rst_strobes", {ce_a[0], oen_a[0], wen_a[0], ub_a[0], lb_a[0]}, 5'b11111);
    chk("rst_dq_oe", oe_a[0], 0);
    chk("rst_dout", dout_a[0], 0);
    chk("rst_addr", addr_a[0], 0);
    chk("rst_dq_out", dq_out_a[0], 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin sel = 1; r = 1; addr = 16'h2468; end
      if (c == 1) addr = 16'hFFFE;
      if (c == 4) run = 1;
      if (c == 5) begin sel = 0; r = 0; run = 0; end
      @(negedge clk);
      chk($sformatf("rd_oe_c%0d", c), oen_a[0], (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("rd_ready_c%0d", c), ready_a[0], (c == 4 || c == 5) ? 1 : 0);
      if (c == 1) chk("rd_setup", {ce_a[0], ub_a[0], lb_a[0], oe_a[0]}, 4'b0000);
      if (c == 4) begin
        chk("rd_dout", dout_a[0], 16'hBEEF);
        chk("rd_addr", addr_a[0], 18'h01234);
        chk("rd_done_ce", ce_a[0], 0);
      end
      if (c == 5) chk("rd_idle_ce", ce_a[0], 1);
    end
    nwe = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin sel = 1; w = 2'b10; din = 16'hA5C3; addr = 16'h0010; end
      if (c == 2) din = 16'h0000;
      if (c == 10) run = 1;
      if (c == 11) begin sel = 0; w = 0; run = 0; end
      @(negedge clk);
      if (!wen_a[0]) nwe++;
      if (c == 1) chk("bw_lanes", {ub_a[0], lb_a[0], oe_a[0], wen_a[0]}, 4'b0111);
      if (c >= 1 && c <= 10) chk($sformatf("bw_dq_oe_c%0d", c), oe_a[0], 1);
      if (c >= 4 && c <= 10) chk($sformatf("bw_stall_ready_c%0d", c), ready_a[0], 1);
      if (c == 11) chk("bw_idle", {ce_a[0], oe_a[0], ready_a[0]}, 3'b101);
    end
    chk("bw_we_pulses", nwe, 2);
    chk("bw_mem", mem[8'h08], 16'hA534);
    chk("bw_dout_kept", dout_a[0], 16'hBEEF);
    nwe = 0; noe = 0;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (c == 0) begin sel = 1; w = 2'b11; r = 0; din = 16'h1111; addr = 16'h0100; run = 1; end
      if (c == 5) begin w = 0; r = 1; end
      if (c == 10) begin sel = 0; r = 0; run = 0; end
      @(negedge clk);
      if (!wen_a[0]) nwe++;
      if (!oen_a[0]) noe++;
      if (c < 10) chk($sformatf("b2b_ready_c%0d", c), ready_a[0], (c == 4 || c == 9) ? 1 : 0);
      if (c == 7) chk("b2b_oe_c7", oen_a[0], 0);
      if (c == 9) chk("b2b_dout", dout_a[0], 16'h1111);
    end
    chk("b2b_we_cnt", nwe, 2);
    chk("b2b_oe_cnt", noe, 2);
    noe = 0; nwe = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin sel = 1; r = 1; w = 2'b11; din = 16'h7E7E; addr = 16'h0010; run = 1; end
      if (c == 5) begin sel = 0; r = 0; w = 0; run = 0; end
      @(negedge clk);
      if (!wen_a[0]) nwe++;
      if (!oen_a[0]) noe++;
      if (c == 4) chk("rw_ready", ready_a[0], 1);
    end
    chk("rw_oe_never", noe, 0);
    chk("rw_we_cnt", nwe, 2);
    chk("rw_dout_kept", dout_a[0], 16'h1111);
    chk("rw_mem", mem[8'h08], 16'h7E7E);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) begin sel = 1; w = 2'b01; din = 16'h5555; addr = 16'h0200; end
      @(negedge clk);
    end
    chk("rst_mid_we_low", {wen_a[0], ce_a[0], oe_a[0]}, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {wen_a[0], ce_a[0], oe_a[0], ready_a[0]}, 4'b1101);
    tick();
    reset = 1'b0; sel = 0; w = 0;
    @(negedge clk);
    chk("rst_rel_idle", {ce_a[0], ready_a[0]}, 2'b11);
    tick();
    sel = 1; r = 1; addr = 16'h0004; run = 0;
    @(negedge clk);
    chk("rst_rel_req", {ce_a[0], ready_a[0]}, 2'b10);
    tick();
    @(negedge clk);
    chk("rst_rel_setup", ce_a[0], 0);
    #2 reset = 1'b1;
    tick();
    reset = 1'b0; sel = 0; r = 0;
    lat = '{-1, -1, -1};
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) begin sel = 1; r = 1; addr = 16'h0004; run = 0; end
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (lat[i] < 0 && ready_a[i]) lat[i] = c;
    end
    chk("lat_w2", lat[0], 4);
    chk("lat_w1", lat[1], 3);
    chk("lat_w15", lat[2], 17);
    tick();
    sel = 0; r = 0;
    @(negedge clk);
    chk("lat_exit", ce_a, 3'b000);
    tick();
    @(negedge clk);
    chk("lat_idle", ce_a, 3'b111);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
